fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch front end. Owns the PC, issues single-outstanding requests to instruction memory, and presents the returned word on instrF to the IF/ID pipeline register.
- Produces the instruction stream that the decode-side register consumes. Honours stallF from the hazard unit and redirects from branch/jump resolution.
- Emits a bubble (ZERO_WORD) whenever no valid instruction is held, so an empty fetch looks identical to a flushed slot downstream.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; low 2 bits must be 0.
- PC_STEP, 4, PC increment per consumed instruction.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  synchronous, active-low reset; sampled on posedge clk.
- stallF  input  1  hazard unit holds fetch; the presented instruction is not consumed.
- redirect  input  1  branch/jump taken; replaces PC and squashes in-flight work.
- redirect_pc  input  `WORD_WIDTH  target PC; bits [1:0] are forced to 0 internally.
- imem_req  output  1  one-cycle request pulse; memory always accepts.
- imem_addr  output  `WORD_WIDTH  request address, valid while imem_req=1.
- imem_rvalid  input  1  response strobe; arrives ≥1 cycle after imem_req.
- imem_rdata  input  `WORD_WIDTH  response data, valid while imem_rvalid=1.
- instrF  output  `WORD_WIDTH  instruction to IF/ID; ZERO_WORD when invalid.
- pcF  output  `WORD_WIDTH  PC of instrF.
- instr_validF  output  1  instrF holds a real instruction.
- fetch_bubble  output  1  equals ~instr_validF; the hazard unit uses it to bubble D.

Behaviour:
- Reset (rst=0 at posedge):
  - pc<=RESET_PC, state<=IDLE.
  - instrF<=ZERO_WORD, pcF<=0, instr_validF<=0.
  - Reset overrides every other input and abandons any outstanding request; a later rvalid is ignored.
- Registered outputs: instrF, pcF, instr_validF. Decoded from state: imem_req=(state==ISSUE), imem_addr=pc.
- At most one request is outstanding. rvalid in IDLE, ISSUE or PRESENT is a protocol violation and is ignored.
- redirect takes priority over stallF and over rvalid capture in every state.
- States and transitions:
  - IDLE:
    - redirect: pc<=redirect_pc.
    - Always -> ISSUE next cycle.
  - ISSUE: imem_req=1.
    - redirect: pc<=redirect_pc -> DROP; the issued request is squashed.
    - Otherwise -> WAIT.
  - WAIT:
    - redirect & rvalid: discard data, pc<=redirect_pc -> ISSUE.
    - redirect & !rvalid: pc<=redirect_pc -> DROP.
    - rvalid (no redirect): instrF<=imem_rdata, pcF<=pc, instr_validF<=1 -> PRESENT.
    - Otherwise stay.
  - PRESENT:
    - redirect: instrF<=ZERO_WORD, instr_validF<=0, pc<=redirect_pc -> ISSUE.
    - stallF: hold all outputs and pc.
    - Otherwise (consumed): instrF<=ZERO_WORD, instr_validF<=0, pc<=pc+PC_STEP -> ISSUE.
  - DROP:
    - rvalid: discard; if redirect is also asserted, pc<=redirect_pc. -> ISSUE.
    - redirect without rvalid: pc<=redirect_pc, stay DROP.
- Arithmetic: pc+PC_STEP wraps modulo 2^32 with no flag. 32'hFFFF_FFFC+4 -> 0.
- Throughput: 1 instruction per (memory latency + 2) cycles minimum, i.e. one per 3 cycles at latency 1.
- instrF/pcF change only on rvalid capture, consume, redirect from PRESENT, or reset.

Test Plan:
- Reset release, memory latency 1 returning 32'h0000_0013 then 32'h0040_0093 -> imem_addr 0 then 4; instrF shows each word for 1 cycle; pcF=0 then 4; fetch_bubble=1 between them.
- In PRESENT with instrF=32'h1234_5678, hold stallF=1 for 5 cycles -> instrF, pcF and instr_validF stable, imem_req=0; on release the next request goes to pc+4.
- redirect=1, redirect_pc=32'h0000_0103 in WAIT, rvalid 2 cycles later with 32'hDEAD_BEEF -> DEAD_BEEF never reaches instrF; next imem_addr=32'h0000_0100.
- redirect and stallF together in PRESENT -> redirect wins: instr_validF=0, instrF=0, next request to redirect_pc.
- Start at RESET_PC=32'hFFFF_FFFC, consume one instruction -> next imem_addr=32'h0000_0000.
- rst=0 asserted in WAIT, stale rvalid arrives 1 cycle after release -> ignored; fetch restarts at RESET_PC with instr_validF=0.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, keeps one imem request in flight,
// and presents the returned word to IF/ID (ZERO_WORD whenever nothing valid is held).
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

module fetch_unit #(
    parameter logic [`WORD_WIDTH-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [`WORD_WIDTH-1:0] PC_STEP  = 32'd4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stallF,
    input  logic                   redirect,
    input  logic [`WORD_WIDTH-1:0] redirect_pc,
    output logic                   imem_req,
    output logic [`WORD_WIDTH-1:0] imem_addr,
    input  logic                   imem_rvalid,
    input  logic [`WORD_WIDTH-1:0] imem_rdata,
    output logic [`WORD_WIDTH-1:0] instrF,
    output logic [`WORD_WIDTH-1:0] pcF,
    output logic                   instr_validF,
    output logic                   fetch_bubble
);

    localparam logic [`WORD_WIDTH-1:0] ZERO_WORD = '0;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ISSUE   = 3'd1;
    localparam logic [2:0] S_WAIT    = 3'd2;
    localparam logic [2:0] S_PRESENT = 3'd3;
    localparam logic [2:0] S_DROP    = 3'd4;

    logic [2:0]             r_state;
    logic [2:0]             w_state_nxt;
    logic [`WORD_WIDTH-1:0] r_pc;
    logic [`WORD_WIDTH-1:0] w_pc_nxt;
    logic [`WORD_WIDTH-1:0] r_instr;
    logic [`WORD_WIDTH-1:0] w_instr_nxt;
    logic [`WORD_WIDTH-1:0] r_pcF;
    logic [`WORD_WIDTH-1:0] w_pcF_nxt;
    logic                   r_vld;
    logic                   w_vld_nxt;
    logic [`WORD_WIDTH-1:0] w_redir_pc;
    logic [`WORD_WIDTH-1:0] w_pc_inc;
    logic                   w_unused;

    // Targets are always word-aligned; the low address bits are dropped.
    assign w_redir_pc = {redirect_pc[`WORD_WIDTH-1:2], 2'b00};
    assign w_unused   = ^redirect_pc[1:0];
    assign w_pc_inc   = r_pc + PC_STEP;

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_instr_nxt = r_instr;
        w_pcF_nxt   = r_pcF;
        w_vld_nxt   = r_vld;
        case (r_state)
            S_IDLE: begin
                if (redirect) w_pc_nxt = w_redir_pc;
                w_state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                if (redirect) begin
                    w_pc_nxt    = w_redir_pc;
                    w_state_nxt = S_DROP;
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect) begin
                    // A response arriving alongside the redirect retires the old request.
                    w_pc_nxt    = w_redir_pc;
                    w_state_nxt = imem_rvalid ? S_ISSUE : S_DROP;
                end else if (imem_rvalid) begin
                    w_instr_nxt = imem_rdata;
                    w_pcF_nxt   = r_pc;
                    w_vld_nxt   = 1'b1;
                    w_state_nxt = S_PRESENT;
                end
            end
            S_PRESENT: begin
                if (redirect) begin
                    w_instr_nxt = ZERO_WORD;
                    w_vld_nxt   = 1'b0;
                    w_pc_nxt    = w_redir_pc;
                    w_state_nxt = S_ISSUE;
                end else if (!stallF) begin
                    w_instr_nxt = ZERO_WORD;
                    w_vld_nxt   = 1'b0;
                    w_pc_nxt    = w_pc_inc;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_DROP: begin
                if (redirect) w_pc_nxt = w_redir_pc;
                if (imem_rvalid) w_state_nxt = S_ISSUE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_pc    <= RESET_PC;
            r_instr <= ZERO_WORD;
            r_pcF   <= '0;
            r_vld   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_instr <= w_instr_nxt;
            r_pcF   <= w_pcF_nxt;
            r_vld   <= w_vld_nxt;
        end
    end

    assign imem_req     = (r_state == S_ISSUE);
    assign imem_addr    = r_pc;
    assign instrF       = r_instr;
    assign pcF          = r_pcF;
    assign instr_validF = r_vld;
    assign fetch_bubble = ~r_vld;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: latency-programmable imem model plus a scoreboard of
// expected (pc, instr) pairs popped whenever a new instruction is presented.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

module tb_fetch_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b0, stallF = 1'b0, redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req, imem_rvalid = 1'b0;
    logic [31:0] imem_addr, imem_rdata = '0;
    logic [31:0] instrF, pcF;
    logic        instr_validF, fetch_bubble;

    logic        rst_w = 1'b0, rvalid_w = 1'b0;
    logic [31:0] rdata_w = '0;
    logic        req_w, v_w, bub_w;
    logic [31:0] addr_w, instr_w, pcF_w;

    fetch_unit dut (
        .clk(clk), .rst(rst), .stallF(stallF), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instrF(instrF), .pcF(pcF), .instr_validF(instr_validF), .fetch_bubble(fetch_bubble)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk(clk), .rst(rst_w), .stallF(1'b0), .redirect(1'b0), .redirect_pc(32'h0),
        .imem_req(req_w), .imem_addr(addr_w), .imem_rvalid(rvalid_w), .imem_rdata(rdata_w),
        .instrF(instr_w), .pcF(pcF_w), .instr_validF(v_w), .fetch_bubble(bub_w)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    logic [31:0] mem_ovr [logic [31:0]];
    int          n_vec = 0, n_err = 0;
    int          lat = 1, m_cnt = 0;
    logic [31:0] m_addr = '0;
    bit          mon_en = 1'b0;
    logic        prev_v = 1'b0;

    function automatic logic [31:0] exp_word(input logic [31:0] a);
        if (mem_ovr.exists(a)) return mem_ovr[a];
        return a ^ 32'hC0DE_0000;
    endfunction

    // Memory model: answers the request seen in cycle c during cycle c+lat.
    always @(negedge clk) begin
        imem_rvalid = 1'b0;
        if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = exp_word(m_addr);
            end
        end
        if (imem_req === 1'b1) begin
            m_cnt  = lat;
            m_addr = imem_addr;
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            n_vec++;
            if (fetch_bubble !== ~instr_validF) begin
                n_err++;
                $display("FAIL bubble: fetch_bubble=%b want %b", fetch_bubble, ~instr_validF);
            end
            if (instr_validF === 1'b1 && prev_v !== 1'b1) begin
                n_vec++;
                if (sb_q.size() == 0) begin
                    n_err++;
                    $display("FAIL sb_unexpected: got pc=%h instr=%h, want nothing", pcF, instrF);
                end else begin
                    mon_e = sb_q.pop_front();
                    if ({pcF, instrF} !== mon_e) begin
                        n_err++;
                        $display("FAIL sb_instr: got pc=%h instr=%h want pc=%h instr=%h",
                                 pcF, instrF, mon_e.pc, mon_e.instr);
                    end
                end
            end
        end
        prev_v <= instr_validF;
    end

    task automatic wait_req(output bit got, output logic [31:0] a);
        got = 1'b0;
        a   = 'x;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (imem_req === 1'b1) begin
                got = 1'b1;
                a   = imem_addr;
            end
        end
    endtask

    // Stall at the next presented instruction so each test starts from a held PRESENT.
    task automatic park();
        bit got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (instr_validF === 1'b1) begin
                stallF = 1'b1;
                got    = 1'b1;
            end
        end
        n_vec++;
        if (!got) begin n_err++; $display("FAIL park_timeout: instr_validF got 0 want 1"); end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_vec++;
        if ({instr_validF, instrF, pcF, imem_req, fetch_bubble, imem_addr} !== {1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0}) begin
            n_err++;
            $display("FAIL reset_state: got v=%b i=%h pc=%h req=%b bub=%b addr=%h want 0/0/0/0/1/0",
                     instr_validF, instrF, pcF, imem_req, fetch_bubble, imem_addr);
        end
        mon_en = 1'b1;
    endtask

    task automatic test_basic();
        bit got; logic [31:0] a;
        mem_ovr[32'h0] = 32'h0000_0013;
        mem_ovr[32'h4] = 32'h0040_0093;
        sb_q.push_back({32'h0, 32'h0000_0013});
        sb_q.push_back({32'h4, 32'h0040_0093});
        rst = 1'b1;
        wait_req(got, a);
        n_vec++;
        if (!got || a !== 32'h0) begin n_err++; $display("FAIL basic_addr0: got %h (seen=%0b) want 0", a, got); end
        @(negedge clk);
        n_vec++;
        if (fetch_bubble !== 1'b1) begin n_err++; $display("FAIL basic_wait_bubble: got %b want 1", fetch_bubble); end
        @(negedge clk);
        n_vec++;
        if ({instr_validF, instrF, pcF} !== {1'b1, 32'h0000_0013, 32'h0}) begin
            n_err++; $display("FAIL basic_present0: got v=%b i=%h pc=%h want 1/00000013/0", instr_validF, instrF, pcF);
        end
        @(negedge clk);
        n_vec++;
        if ({imem_req, imem_addr, fetch_bubble, instrF} !== {1'b1, 32'h4, 1'b1, 32'h0}) begin
            n_err++; $display("FAIL basic_issue4: got req=%b addr=%h bub=%b i=%h want 1/4/1/0", imem_req, imem_addr, fetch_bubble, instrF);
        end
        repeat (2) @(negedge clk);
        n_vec++;
        if ({instr_validF, instrF, pcF} !== {1'b1, 32'h0040_0093, 32'h4}) begin
            n_err++; $display("FAIL basic_present4: got v=%b i=%h pc=%h want 1/00400093/4", instr_validF, instrF, pcF);
        end
        stallF = 1'b1;
    endtask

    task automatic test_stall();
        bit got; logic [31:0] a;
        @(negedge clk);
        mem_ovr[32'h8] = 32'h1234_5678;
        sb_q.push_back({32'h8, 32'h1234_5678});
        stallF = 1'b0;
        wait_req(got, a);
        n_vec++;
        if (!got || a !== 32'h8) begin n_err++; $display("FAIL stall_addr8: got %h (seen=%0b) want 8", a, got); end
        repeat (2) @(negedge clk);
        stallF = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_vec++;
            if ({instr_validF, instrF, pcF, imem_req} !== {1'b1, 32'h1234_5678, 32'h8, 1'b0}) begin
                n_err++; $display("FAIL stall_hold%0d: got v=%b i=%h pc=%h req=%b want 1/12345678/8/0",
                                  i, instr_validF, instrF, pcF, imem_req);
            end
        end
        sb_q.push_back({32'hC, exp_word(32'hC)});
        stallF = 1'b0;
        wait_req(got, a);
        n_vec++;
        if (!got || a !== 32'hC) begin n_err++; $display("FAIL stall_release_addr: got %h (seen=%0b) want c", a, got); end
        park();
    endtask

    task automatic test_redirect_wait();
        bit got; logic [31:0] a;
        @(negedge clk);
        lat = 3;
        mem_ovr[32'h10] = 32'hDEAD_BEEF;
        stallF = 1'b0;
        wait_req(got, a);
        n_vec++;
        if (!got || a !== 32'h10) begin n_err++; $display("FAIL redir_wait_addr: got %h (seen=%0b) want 10", a, got); end
        @(negedge clk);
        redirect = 1'b1; redirect_pc = 32'h0000_0103;
        sb_q.push_back({32'h100, exp_word(32'h100)});
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            redirect = 1'b0;
            n_vec++;
            if (instr_validF !== 1'b0 || instrF === 32'hDEAD_BEEF) begin
                n_err++; $display("FAIL redir_wait_squash%0d: got v=%b i=%h want 0/not deadbeef", i, instr_validF, instrF);
            end
        end
        n_vec++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h100}) begin
            n_err++; $display("FAIL redir_wait_target: got req=%b addr=%h want 1/100", imem_req, imem_addr);
        end
        park();
    endtask

    task automatic test_redirect_rvalid();
        bit got; logic [31:0] a;
        @(negedge clk);
        lat = 1;
        stallF = 1'b0;
        wait_req(got, a);
        n_vec++;
        if (!got || a !== 32'h104) begin n_err++; $display("FAIL redir_rv_addr: got %h (seen=%0b) want 104", a, got); end
        @(negedge clk);
        redirect = 1'b1; redirect_pc = 32'h0000_0300;
        sb_q.push_back({32'h300, exp_word(32'h300)});
        @(negedge clk);
        redirect = 1'b0;
        n_vec++;
        if ({imem_req, imem_addr, instr_validF} !== {1'b1, 32'h300, 1'b0}) begin
            n_err++; $display("FAIL redir_rv_target: got req=%b addr=%h v=%b want 1/300/0", imem_req, imem_addr, instr_validF);
        end
        park();
    endtask

    task automatic test_redirect_stall();
        @(negedge clk);
        redirect = 1'b1; redirect_pc = 32'h0000_0200;
        sb_q.push_back({32'h200, exp_word(32'h200)});
        @(negedge clk);
        redirect = 1'b0;
        n_vec++;
        if ({instr_validF, instrF, imem_req, imem_addr} !== {1'b0, 32'h0, 1'b1, 32'h200}) begin
            n_err++; $display("FAIL redir_stall: got v=%b i=%h req=%b addr=%h want 0/0/1/200",
                              instr_validF, instrF, imem_req, imem_addr);
        end
        park();
    endtask

    task automatic test_reset_wait();
        bit got; logic [31:0] a;
        @(negedge clk);
        lat = 3;
        stallF = 1'b0;
        wait_req(got, a);
        n_vec++;
        if (!got || a !== 32'h204) begin n_err++; $display("FAIL rst_wait_addr: got %h (seen=%0b) want 204", a, got); end
        @(negedge clk);
        rst = 1'b0;
        sb_q.push_back({32'h0, exp_word(32'h0)});
        @(negedge clk);
        n_vec++;
        if ({instr_validF, instrF, pcF, imem_req} !== {1'b0, 32'h0, 32'h0, 1'b0}) begin
            n_err++; $display("FAIL rst_wait_state: got v=%b i=%h pc=%h req=%b want 0/0/0/0", instr_validF, instrF, pcF, imem_req);
        end
        rst = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({imem_req, imem_addr, instr_validF} !== {1'b1, 32'h0, 1'b0}) begin
            n_err++; $display("FAIL rst_wait_restart: got req=%b addr=%h v=%b want 1/0/0", imem_req, imem_addr, instr_validF);
        end
        @(negedge clk);
        n_vec++;
        if (instr_validF !== 1'b0) begin n_err++; $display("FAIL rst_wait_stale: got v=%b want 0", instr_validF); end
        park();
    endtask

    task automatic test_back_to_back();
        int last = 0, nrise = 0;
        logic pv = 1'b1;
        @(negedge clk);
        lat = 1;
        for (int k = 1; k <= 4; k++) sb_q.push_back({32'(4 * k), exp_word(32'(4 * k))});
        stallF = 1'b0;
        for (int i = 1; i <= 40 && nrise < 4; i++) begin
            @(negedge clk);
            if (instr_validF === 1'b1 && pv !== 1'b1) begin
                n_vec++;
                if (i - last != 3) begin n_err++; $display("FAIL b2b_spacing: got %0d cycles want 3", i - last); end
                last = i;
                nrise++;
                if (nrise == 4) stallF = 1'b1;
            end
            pv = instr_validF;
        end
        n_vec++;
        if (nrise != 4) begin n_err++; $display("FAIL b2b_count: got %0d instrs want 4", nrise); end
    endtask

    task automatic test_wrap();
        bit got = 1'b0;
        @(negedge clk);
        rst_w = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (req_w === 1'b1) got = 1'b1;
        end
        n_vec++;
        if (!got || addr_w !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_first: got %h (seen=%0b) want fffffffc", addr_w, got); end
        @(negedge clk);
        rvalid_w = 1'b1; rdata_w = 32'h0000_0013;
        @(negedge clk);
        rvalid_w = 1'b0;
        n_vec++;
        if ({v_w, pcF_w, instr_w, bub_w} !== {1'b1, 32'hFFFF_FFFC, 32'h13, 1'b0}) begin
            n_err++; $display("FAIL wrap_present: got v=%b pc=%h i=%h bub=%b want 1/fffffffc/13/0", v_w, pcF_w, instr_w, bub_w);
        end
        @(negedge clk);
        n_vec++;
        if ({req_w, addr_w} !== {1'b1, 32'h0}) begin
            n_err++; $display("FAIL wrap_next: got req=%b addr=%h want 1/0", req_w, addr_w);
        end
        rst_w = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_redirect_wait();
        test_redirect_rvalid();
        test_redirect_stall();
        test_reset_wait();
        test_back_to_back();
        test_wrap();
        @(negedge clk);
        n_vec++;
        if (sb_q.size() != 0) begin n_err++; $display("FAIL sb_leftover: got %0d pending want 0", sb_q.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
